// File: rtl/reg_file_wr_arbiter_if.sv
// reg_file_wr_arbiter_if
// Bundles the two write-requester handshakes and the register-file write
// port driven by the arbiter.
//   req0_* / req1_*  : valid/addr/data from requesters, ready back to them
//   write_data       : value to write into the register file
//   write_register   : destination register index
//   wr               : register-file write enable
//   init_done        : post-reset clear sweep finished
//   conflict_cnt     : saturating count of contended arbitration cycles
// master = requester/register-file side, slave = arbiter side.
interface reg_file_wr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
);
  logic             req0_valid;
  logic [DEPTH-1:0] req0_addr;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [DEPTH-1:0] req1_addr;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic [WIDTH-1:0] write_data;
  logic [DEPTH-1:0] write_register;
  logic             wr;
  logic             init_done;
  logic [15:0]      conflict_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  write_data, write_register, wr, init_done, conflict_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output write_data, write_register, wr, init_done, conflict_cnt
  );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter
// Two-requester round-robin write arbiter in front of a register file.
// After reset it first sweeps zeros into registers 1..2**DEPTH-1 (CLEAR),
// then grants one write per cycle (ARB). Writes to register 0 complete the
// handshake but never assert wr.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : reg_file_wr_arbiter_if.slave (requesters + register-file port)
module reg_file_wr_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_wr_arbiter_if.slave  bus
);

  typedef enum logic {CLEAR = 1'b0, ARB = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] clr_ptr_q, clr_ptr_d;
  logic             last_gnt_q, last_gnt_d;
  logic             wr_q, wr_d;
  logic [DEPTH-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             init_done_q, init_done_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             gnt0, gnt1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    last_gnt_d  = last_gnt_q;
    wr_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    init_done_d = init_done_q;
    cnt_d       = cnt_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_d      = 1'b1;
        wreg_d    = clr_ptr_q;
        wdata_d   = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d     = ARB;
          init_done_d = 1'b1;
        end
      end
      ARB: begin
        // On contention the requester that did not win last time goes first.
        if (bus.req0_valid && bus.req1_valid) begin
          cnt_d = sat_inc16(cnt_q);
          if (last_gnt_q) gnt0 = 1'b1;
          else            gnt1 = 1'b1;
        end else if (bus.req0_valid) begin
          gnt0 = 1'b1;
        end else if (bus.req1_valid) begin
          gnt1 = 1'b1;
        end
        // Register 0 is read-only: accept the write but keep wr low.
        if (gnt0) begin
          wreg_d     = bus.req0_addr;
          wdata_d    = bus.req0_data;
          wr_d       = (bus.req0_addr != '0);
          last_gnt_d = 1'b0;
        end else if (gnt1) begin
          wreg_d     = bus.req1_addr;
          wdata_d    = bus.req1_data;
          wr_d       = (bus.req1_addr != '0);
          last_gnt_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= DEPTH'(1);
      last_gnt_q  <= 1'b1;
      wr_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      last_gnt_q  <= last_gnt_d;
      wr_q        <= wr_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      cnt_q       <= cnt_d;
    end
  end

  // Grants are gated by rst so nothing is accepted on a reset edge.
  assign bus.req0_ready     = gnt0 & ~rst;
  assign bus.req1_ready     = gnt1 & ~rst;
  assign bus.write_data     = wdata_q;
  assign bus.write_register = wreg_q;
  assign bus.wr             = wr_q;
  assign bus.init_done      = init_done_q;
  assign bus.conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// tb_reg_file_wr_arbiter
// Directed bench: reset state, full clear sweep, table of arbitration
// vectors, reset mid-sweep and reset while a request is pending.
module tb_reg_file_wr_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_wr_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_file_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        wr;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [12];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic r0, input logic r1, input logic wr,
                              input logic [4:0] wreg, input logic [31:0] wdata,
                              input logic [15:0] cnt);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.wr = wr; v.wreg = wreg; v.wdata = wdata; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  // Sweep writes 1..n; readys must stay low, init_done only on write 31.
  task automatic sweep(input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      #1;
      chk($sformatf("%s r0 %0d", tag, i), bus.req0_ready, 1'b0);
      chk($sformatf("%s r1 %0d", tag, i), bus.req1_ready, 1'b0);
      step();
      chk($sformatf("%s wr %0d", tag, i), bus.wr, 1'b1);
      chk($sformatf("%s wreg %0d", tag, i), bus.write_register, i[4:0]);
      chk($sformatf("%s wdata %0d", tag, i), bus.write_data, 32'd0);
      chk($sformatf("%s init %0d", tag, i), bus.init_done, (i == 31));
    end
  endtask

  initial begin
    // idle, req1->r0, contention x4, idle, req0 r5, idle, req1 r3, contention, idle
    tbl[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 7, 32'h77, 0);
    tbl[1]  = mk(0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'hFFFFFFFF, 0);
    tbl[2]  = mk(1, 1, 1,            1, 2, 2,            1, 0, 1, 1, 1, 1);
    tbl[3]  = mk(1, 1, 1,            1, 2, 2,            0, 1, 1, 2, 2, 2);
    tbl[4]  = mk(1, 1, 1,            1, 2, 2,            1, 0, 1, 1, 1, 3);
    tbl[5]  = mk(1, 1, 1,            1, 2, 2,            0, 1, 1, 2, 2, 4);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 2, 2, 4);
    tbl[7]  = mk(1, 5, 32'hA5A5A5A5, 0, 0, 0,            1, 0, 1, 5, 32'hA5A5A5A5, 4);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 5, 32'hA5A5A5A5, 4);
    tbl[9]  = mk(0, 0, 0,            1, 3, 32'h33,       0, 1, 1, 3, 32'h33, 4);
    tbl[10] = mk(1, 4, 32'h44,       1, 6, 32'h66,       1, 0, 1, 4, 32'h44, 5);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 4, 32'h44, 5);

    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst wr", bus.wr, 1'b0);
    chk("rst wreg", bus.write_register, 5'd0);
    chk("rst wdata", bus.write_data, 32'd0);
    chk("rst init", bus.init_done, 1'b0);
    chk("rst cnt", bus.conflict_cnt, 16'd0);

    // req1 held pending through the sweep, served on the first ARB cycle
    rst = 1'b0;
    set_req(0, 0, 0, 1, 7, 32'h77);
    sweep(31, "sweep");
    #1;
    chk("first arb r0", bus.req0_ready, 1'b0);
    chk("first arb r1", bus.req1_ready, 1'b1);
    step();
    chk("pend wr", bus.wr, 1'b1);
    chk("pend wreg", bus.write_register, 5'd7);
    chk("pend wdata", bus.write_data, 32'h77);

    for (int i = 0; i < 12; i++) begin
      set_req(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("vec%0d r0", i), bus.req0_ready, tbl[i].r0);
      chk($sformatf("vec%0d r1", i), bus.req1_ready, tbl[i].r1);
      step();
      chk($sformatf("vec%0d wr", i), bus.wr, tbl[i].wr);
      chk($sformatf("vec%0d wreg", i), bus.write_register, tbl[i].wreg);
      chk($sformatf("vec%0d wdata", i), bus.write_data, tbl[i].wdata);
      chk($sformatf("vec%0d cnt", i), bus.conflict_cnt, tbl[i].cnt);
    end

    // reset while a request is pending in ARB: no grant, everything cleared
    set_req(1, 9, 32'h99, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rstarb r0", bus.req0_ready, 1'b0);
    chk("rstarb r1", bus.req1_ready, 1'b0);
    step();
    chk("rstarb wr", bus.wr, 1'b0);
    chk("rstarb wreg", bus.write_register, 5'd0);
    chk("rstarb wdata", bus.write_data, 32'd0);
    chk("rstarb init", bus.init_done, 1'b0);
    chk("rstarb cnt", bus.conflict_cnt, 16'd0);
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);

    // reset pulse at sweep cycle 10, then a full fresh sweep
    sweep(9, "part");
    rst = 1'b1;
    step();
    chk("mid wr", bus.wr, 1'b0);
    chk("mid wreg", bus.write_register, 5'd0);
    chk("mid init", bus.init_done, 1'b0);
    rst = 1'b0;
    sweep(31, "resweep");

    // after reset req0 wins the first contention
    set_req(1, 10, 32'hAA, 1, 11, 32'hBB);
    #1;
    chk("post r0", bus.req0_ready, 1'b1);
    chk("post r1", bus.req1_ready, 1'b0);
    step();
    chk("post wreg", bus.write_register, 5'd10);
    chk("post wdata", bus.write_data, 32'hAA);
    chk("post cnt", bus.conflict_cnt, 16'd1);
    set_req(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
